// File: rtl/elelock_ctrl_if.sv
// elelock_ctrl_if: scanner key/tick inputs and lock status outputs of elelock_ctrl
// master: keycode, keyenbl, tick out; lock, alarm, entbuf, digcnt, errcnt, state in
// slave: the reverse, used by elelock_ctrl
interface elelock_ctrl_if;
  logic [3:0] keycode;
  logic keyenbl, tick, lock, alarm;
  logic [15:0] entbuf;
  logic [2:0] digcnt, errcnt;
  logic [1:0] state;
  modport master(output keycode, keyenbl, tick, input lock, alarm, entbuf, digcnt, errcnt, state);
  modport slave(input keycode, keyenbl, tick, output lock, alarm, entbuf, digcnt, errcnt, state);
endinterface

// File: rtl/elelock_ctrl.sv
// elelock_ctrl: 4-digit keypad lock with auto-relock, wrong-entry lockout and optional code change (ELELOCK_SETCODE_EN)
// ck/reset: clock, async active-high reset
// bus.keycode/keyenbl: scanner key and level strobe; bus.tick: timebase pulse
// bus.lock/alarm/entbuf/digcnt/errcnt/state: registered status outputs
module elelock_ctrl #(
  parameter logic [15:0] INIT_CODE = 16'h1234,
  parameter logic [7:0] OPEN_TICKS = 8'd10,
  parameter logic [2:0] MAX_ERR = 3'd3,
  parameter logic [7:0] LOCK_TICKS = 8'd30
) (
  input logic ck,
  input logic reset,
  elelock_ctrl_if.slave bus
);
  typedef enum logic [1:0] {LOCKED = 2'b00, OPEN = 2'b01, LOCKOUT = 2'b10, SET = 2'b11} st_t;
  st_t st, st_n;
  logic lock, lock_n, alarm, alarm_n, en_d;
  logic [15:0] entbuf, entbuf_n, code, sh;
  logic [2:0] digcnt, digcnt_n, errcnt, errcnt_n, dc;
  logic [7:0] timer, timer_n;
  logic kev, dig, clr, ent, otmo, ltmo;
  assign kev = bus.keyenbl & ~en_d;
  assign dig = kev & (bus.keycode <= 4'd9);
  assign clr = kev & (bus.keycode == 4'hc);
  assign ent = kev & (bus.keycode == 4'he);
  assign otmo = bus.tick & (timer == OPEN_TICKS - 8'd1);
  assign ltmo = bus.tick & (timer == LOCK_TICKS - 8'd1);
  assign sh = {entbuf[11:0], bus.keycode};
  assign dc = digcnt == 3'd4 ? digcnt : digcnt + 3'd1;
`ifdef ELELOCK_SETCODE_EN
  logic [15:0] code_n;
  always_ff @(posedge ck or posedge reset)
    if (reset) code <= INIT_CODE;
    else code <= code_n;
`else
  assign code = INIT_CODE;
`endif
  always_ff @(posedge ck or posedge reset)
    if (reset) begin
      st <= LOCKED;
      lock <= 1'b1;
      alarm <= 1'b0;
      entbuf <= '0;
      digcnt <= '0;
      errcnt <= '0;
      timer <= '0;
      en_d <= 1'b0;
    end else begin
      st <= st_n;
      lock <= lock_n;
      alarm <= alarm_n;
      entbuf <= entbuf_n;
      digcnt <= digcnt_n;
      errcnt <= errcnt_n;
      timer <= timer_n;
      en_d <= bus.keyenbl;
    end
  always_comb begin
    st_n = st;
    lock_n = lock;
    alarm_n = alarm;
    entbuf_n = entbuf;
    digcnt_n = digcnt;
    errcnt_n = errcnt;
    timer_n = timer;
`ifdef ELELOCK_SETCODE_EN
    code_n = code;
`endif
    case (st)
      LOCKED:
        if (dig) begin
          entbuf_n = sh;
          digcnt_n = dc;
        end else if (clr) begin
          entbuf_n = '0;
          digcnt_n = '0;
        end else if (ent) begin
          entbuf_n = '0;
          digcnt_n = '0;
          if (digcnt == 3'd4 && entbuf == code) begin
            st_n = OPEN;
            lock_n = 1'b0;
            errcnt_n = '0;
            timer_n = '0;
          end else begin
            errcnt_n = errcnt + 3'd1;
            if (errcnt + 3'd1 == MAX_ERR) begin
              st_n = LOCKOUT;
              alarm_n = 1'b1;
              timer_n = '0;
            end
          end
        end
      // a digit or CLEAR absorbs a coincident tick because it restarts the timer
      OPEN:
        if (ent || (otmo && !dig && !clr)) begin
          st_n = LOCKED;
          lock_n = 1'b1;
          timer_n = '0;
        end else if (dig || clr) begin
          timer_n = '0;
`ifdef ELELOCK_SETCODE_EN
          if (clr) begin
            st_n = SET;
            entbuf_n = '0;
            digcnt_n = '0;
          end
`endif
        end else if (bus.tick) timer_n = timer + 8'd1;
`ifdef ELELOCK_SETCODE_EN
      // the buffer is wiped on exit so the new code never sits ready for ENTER
      SET:
        if (ent || otmo) begin
          if (ent && digcnt == 3'd4) code_n = entbuf;
          st_n = LOCKED;
          lock_n = 1'b1;
          timer_n = '0;
          entbuf_n = '0;
          digcnt_n = '0;
        end else begin
          if (dig) begin
            entbuf_n = sh;
            digcnt_n = dc;
          end else if (clr) begin
            entbuf_n = '0;
            digcnt_n = '0;
          end
          if (bus.tick) timer_n = timer + 8'd1;
        end
`endif
      LOCKOUT:
        if (ltmo) begin
          st_n = LOCKED;
          alarm_n = 1'b0;
          errcnt_n = '0;
          entbuf_n = '0;
          digcnt_n = '0;
          timer_n = '0;
        end else if (bus.tick) timer_n = timer + 8'd1;
      default: begin
        st_n = LOCKED;
        lock_n = 1'b1;
        alarm_n = 1'b0;
        timer_n = '0;
      end
    endcase
  end
  assign bus.lock = lock;
  assign bus.alarm = alarm;
  assign bus.entbuf = entbuf;
  assign bus.digcnt = digcnt;
  assign bus.errcnt = errcnt;
  assign bus.state = st;
endmodule

// File: tb/tb_elelock_ctrl.sv
// tb_elelock_ctrl: directed and random key/tick stimulus checked against a digit-queue lock model
module tb_elelock_ctrl;
  localparam int OPEN_T = 10, MAXE = 3, LOCK_T = 30;
  logic ck = 1'b0, reset = 1'b1;
  always #5 ck = ~ck;
  elelock_ctrl_if bus();
  elelock_ctrl dut(.ck(ck), .reset(reset), .bus(bus.slave));
  int total = 0, bad = 0;
  int m_st, m_err, m_tim;
  bit m_lock, m_alarm, m_prev;
  int q[$];
  logic [15:0] m_code;
  task chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] bufval();
    logic [15:0] v = '0;
    foreach (q[i]) v = {v[11:0], 4'(q[i])};
    return v;
  endfunction
  task m_reset();
    m_st = 0; m_err = 0; m_tim = 0; m_lock = 1; m_alarm = 0; m_prev = 0;
    q.delete();
    m_code = 16'h1234;
  endtask
  task to_locked();
    m_st = 0; m_lock = 1; m_tim = 0;
  endtask
  task step(input logic [3:0] k, input logic en, input logic t);
    bit ev, valid;
    ev = en && !m_prev;
    m_prev = en;
    valid = ev && (k <= 9 || k == 4'hc || k == 4'he);
    case (m_st)
      0: if (valid) begin
        if (k <= 9) begin
          q.push_back(int'(k));
          if (q.size() > 4) void'(q.pop_front());
        end else if (k == 4'hc) q.delete();
        else begin
          if (q.size() == 4 && bufval() == m_code) begin
            m_st = 1; m_lock = 0; m_err = 0; m_tim = 0;
          end else begin
            m_err++;
            if (m_err == MAXE) begin m_st = 2; m_alarm = 1; m_tim = 0; end
          end
          q.delete();
        end
      end
      1: if (valid && k == 4'he) to_locked();
        else if (valid) begin
          m_tim = 0;
`ifdef ELELOCK_SETCODE_EN
          if (k == 4'hc) begin m_st = 3; q.delete(); end
`endif
        end else if (t) begin
          if (m_tim + 1 == OPEN_T) to_locked(); else m_tim++;
        end
      2: if (t) begin
        if (m_tim + 1 == LOCK_T) begin
          m_st = 0; m_alarm = 0; m_err = 0; m_tim = 0; q.delete();
        end else m_tim++;
      end
      default: if ((valid && k == 4'he) || (t && m_tim + 1 == OPEN_T)) begin
          if (valid && k == 4'he && q.size() == 4) m_code = bufval();
          to_locked();
          q.delete();
        end else begin
          if (valid && k <= 9) begin
            q.push_back(int'(k));
            if (q.size() > 4) void'(q.pop_front());
          end else if (valid && k == 4'hc) q.delete();
          if (t) m_tim++;
        end
    endcase
  endtask
  task check_all();
    chk("state", 16'(bus.state), 16'(m_st));
    chk("lock", 16'(bus.lock), 16'(m_lock));
    chk("alarm", 16'(bus.alarm), 16'(m_alarm));
    chk("entbuf", bus.entbuf, bufval());
    chk("digcnt", 16'(bus.digcnt), 16'(q.size()));
    chk("errcnt", 16'(bus.errcnt), 16'(m_err));
  endtask
  task cyc(input logic [3:0] k, input logic en, input logic t);
    bus.keycode = k; bus.keyenbl = en; bus.tick = t;
    @(posedge ck);
    step(k, en, t);
    #1 check_all();
  endtask
  task press(input logic [3:0] k);
    cyc(k, 1'b1, 1'b0);
    cyc(4'hf, 1'b0, 1'b0);
  endtask
  task keys(input logic [23:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) press(s[i*4+:4]);
  endtask
  task ticks(input int n);
    repeat (n) cyc(4'hf, 1'b0, 1'b1);
  endtask
  task do_reset();
    bus.keycode = 4'hf; bus.keyenbl = 1'b0; bus.tick = 1'b0;
    reset = 1'b1;
    m_reset();
    #1 check_all();
    @(negedge ck) reset = 1'b0;
  endtask
  initial begin
    bus.keycode = 4'hf; bus.keyenbl = 1'b0; bus.tick = 1'b0;
    #12 do_reset();
    chk("rst_lock", 16'(bus.lock), 16'h1);
    chk("rst_state", 16'(bus.state), 16'h0);
    keys(24'h01234e, 5);
    chk("open", 16'(bus.state), 16'h1);
    chk("open_lock", 16'(bus.lock), 16'h0);
    press(4'he);
    chk("relock", 16'(bus.state), 16'h0);
    repeat (5) cyc(4'h7, 1'b1, 1'b0);
    cyc(4'hf, 1'b0, 1'b0);
    chk("hold_cnt", 16'(bus.digcnt), 16'h1);
    chk("hold_buf", bus.entbuf, 16'h0007);
    press(4'hc);
    keys(24'h91234e, 6);
    chk("last4", 16'(bus.state), 16'h1);
    ticks(9);
    chk("tick9", 16'(bus.lock), 16'h0);
    ticks(1);
    chk("tick10", 16'(bus.lock), 16'h1);
    keys(24'h01111e, 5);
    chk("err1", 16'(bus.errcnt), 16'h1);
    keys(24'h01111e, 5);
    chk("err2", 16'(bus.errcnt), 16'h2);
    keys(24'h01111e, 5);
    chk("lockout", 16'(bus.state), 16'h2);
    chk("alarm_on", 16'(bus.alarm), 16'h1);
    keys(24'h01234e, 5);
    chk("lo_ign", 16'(bus.state), 16'h2);
    ticks(29);
    chk("lo29", 16'(bus.alarm), 16'h1);
    ticks(1);
    chk("lo_end", 16'(bus.alarm), 16'h0);
    chk("lo_err", 16'(bus.errcnt), 16'h0);
    keys(24'h00012e, 3);
    chk("short", 16'(bus.errcnt), 16'h1);
    keys(24'h01234e, 5);
    chk("reopen", 16'(bus.errcnt), 16'h0);
    press(4'he);
    chk("relock2", 16'(bus.state), 16'h0);
`ifdef ELELOCK_SETCODE_EN
    keys(24'h01234e, 5);
    keys(24'hc5678e, 6);
    chk("set_done", 16'(bus.state), 16'h0);
    keys(24'h01234e, 5);
    chk("old_bad", 16'(bus.errcnt), 16'h1);
    keys(24'h05678e, 5);
    chk("new_ok", 16'(bus.state), 16'h1);
    press(4'he);
    keys(24'h000012, 2);
    do_reset();
    keys(24'h01234e, 5);
    chk("code_rst", 16'(bus.state), 16'h1);
`endif
    keys(24'h000003, 1);
    do_reset();
    chk("rst_open", 16'(bus.state), 16'h0);
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 6) begin
        cyc(4'hf, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) press(m_code[i*4+:4]);
        press(4'he);
      end else if (r == 199) do_reset();
      else cyc(4'($urandom_range(0, 15)),
               ($urandom_range(0, 2) == 0) ? ~bus.keyenbl : bus.keyenbl,
               1'($urandom_range(0, 3) == 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/elelock_ctrl.md
Name: elelock_ctrl

Overview:
Electronic-lock controller that sits directly downstream of the tenkey scanner. Consumes the scanner's 4-bit keycode and its keyenbl strobe, and collects a 4-digit entry. On ENTER it compares the entry against a stored code and drives the lock output. Also provides an auto-relock timer, a wrong-entry lockout with alarm, and display outputs for the digits entered.

Parameters:
INIT_CODE, 16'h1234, stored code after reset; 4 BCD nibbles, most significant nibble is the first digit entered.
OPEN_TICKS, 8'd10, tick pulses spent in OPEN before auto-relock; legal range 1..255.
MAX_ERR, 3'd3, consecutive wrong entries that trigger lockout; legal range 1..7.
LOCK_TICKS, 8'd30, tick pulses spent in LOCKOUT; legal range 1..255.

Ports:
ck  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
keycode  in  4  key code from scanner: 0-9 digit, 4'hc CLEAR, 4'he ENTER, 4'hf none; 4'ha/b/d ignored
keyenbl  in  1  key-valid from scanner; level, may stay high for several ck cycles
tick  in  1  timebase pulse, one ck cycle wide
lock  out  1  1 = bolt locked
alarm  out  1  1 while in LOCKOUT
entbuf  out  16  entered digits, newest digit in [3:0]
digcnt  out  3  digits entered, 0..4
errcnt  out  3  consecutive wrong entries
state  out  2  00 LOCKED, 01 OPEN, 10 LOCKOUT, 11 SET

Behaviour:
- Reset values: state=LOCKED, lock=1, alarm=0, entbuf=0, digcnt=0, errcnt=0, timer=0, stored code=INIT_CODE. Reset takes effect immediately, including mid-entry and during OPEN or LOCKOUT.
- Key event: kev = keyenbl & ~keyenbl_d, where keyenbl_d is keyenbl registered on ck (reset value 0). Exactly one event per keyenbl high period. keycode is sampled in the kev cycle.
- All outputs are registered and update on the ck edge that sees kev or tick.
- Digit entry (LOCKED and SET):
  - entbuf <= {entbuf[11:0], keycode}.
  - digcnt increments and saturates at 4. A 5th or later digit keeps shifting, so the last 4 digits are kept.
- CLEAR in LOCKED: entbuf=0, digcnt=0; errcnt unchanged.
- ENTER in LOCKED:
  - If digcnt==4 and entbuf==code: go to OPEN, lock=0, errcnt=0, timer=0.
  - Otherwise: errcnt+1. If the new errcnt==MAX_ERR, go to LOCKOUT with alarm=1 and timer=0.
  - Either way, entbuf and digcnt are cleared.
- OPEN:
  - Each tick increments timer. A tick with timer==OPEN_TICKS-1 moves to LOCKED, lock=1.
  - Any key event clears timer.
  - ENTER relocks immediately to LOCKED.
  - Digits are ignored.
  - ENTER and the final tick in the same cycle: go to LOCKED.
- LOCKOUT:
  - All key events are ignored.
  - A tick with timer==LOCK_TICKS-1 moves to LOCKED, with alarm=0, errcnt=0, entbuf=0, digcnt=0.
- Any state transition clears timer.
- A key event and a tick in the same cycle in LOCKED: the key is processed and the tick has no effect.
- Unused state code 11 (when SET is compiled out) recovers to LOCKED on the next ck.
- Keycodes 4'ha, 4'hb, 4'hd and 4'hf cause no change in any state.

Optional Feature:
ELELOCK_SETCODE_EN:
- Enabled:
  - CLEAR in OPEN enters SET with entbuf=0 and digcnt=0; lock stays 0.
  - In SET, digits shift in and the timer still runs.
  - ENTER with digcnt==4 writes code<=entbuf and goes to LOCKED, lock=1.
  - ENTER with digcnt<4, or the OPEN_TICKS timeout, goes to LOCKED with the code unchanged.
  - CLEAR in SET clears entbuf and digcnt.
- Disabled:
  - CLEAR in OPEN only clears timer.
  - Code is the constant INIT_CODE and the SET state does not exist.

Test Plan:
- Reset, then keys 1,2,3,4,E -> state=OPEN, lock=0, errcnt=0, entbuf=0.
- keyenbl held high 5 ck with keycode=7 -> digcnt=1, entbuf=16'h0007 (single event).
- Keys 9,1,2,3,4,E -> OPEN (last 4 digits kept); then 10 ticks -> lock=1 on the ck after the 10th tick.
- Keys 1,1,1,1,E three times -> errcnt=1,2, then LOCKOUT, alarm=1; key 1,2,3,4,E ignored; after 30 ticks -> LOCKED, alarm=0, errcnt=0.
- Keys 1,2,E -> errcnt=1; then 1,2,3,4,E -> OPEN, errcnt=0; then E -> LOCKED.
- With ELELOCK_SETCODE_EN: open, then C,5,6,7,8,E -> LOCKED; 1,2,3,4,E -> errcnt=1; 5,6,7,8,E -> OPEN. Assert reset mid-entry -> code returns to 16'h1234.
